// File: rtl/hmac_msg_packer.sv
// -----------------------------------------------------------------------------
// hmac_msg_packer
//
// Byte packer that sits in front of the HMAC message FIFO. Bus writes carrying
// any contiguous run of byte strobes are compacted LSB-first into a byte buffer,
// and full Width-bit words are presented on the FIFO write port. A flush request
// drains whatever partial word remains (with its byte mask) and then pulses
// flush_done_o.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           synchronous clear: drop buffered bytes, abort any flush
//   valid_i/ready_o input beat handshake; data_i byte k = data_i[8k+:8],
//                   mask_i = byte strobes (set bits must be contiguous)
//   valid_o/ready_i output word handshake towards the FIFO; data_o, mask_o
//   flush_i         request to drain the residual partial word
//   flush_done_o    one-cycle pulse once a flush has emptied the buffer
//   err_o           one-cycle pulse after an accepted beat with a
//                   non-contiguous mask (that beat is dropped)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer holding valid high keeps its payload unchanged
// until the transfer. ready_o depends only on registered state, never on
// valid_i or ready_i, and data_o/mask_o stay fixed while valid_o & !ready_i.
// -----------------------------------------------------------------------------
module hmac_msg_packer #(
  parameter int Width = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 valid_i,
  input  logic [Width-1:0]     data_i,
  input  logic [Width/8-1:0]   mask_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [Width-1:0]     data_o,
  output logic [Width/8-1:0]   mask_o,
  input  logic                 ready_i,
  input  logic                 flush_i,
  output logic                 flush_done_o,
  output logic                 err_o
);

  localparam int NBytes = Width / 8;
  localparam int BufB   = 2 * NBytes;
  localparam int CntW   = $clog2(2 * NBytes + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                    state_q;
  logic [BufB-1:0][7:0]      buf_q, buf_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      err_q;

  // Combinational helpers
  int                        cnt_int;
  int                        popped;
  int                        base;
  int                        low_idx;
  int                        n_set;
  logic                      found;
  logic                      accept;
  logic                      contig;
  logic                      good_beat;
  logic                      bad_beat;
  logic [NBytes-1:0]         shifted;

  always_comb begin
    cnt_int   = int'(cnt_q);

    ready_o   = (cnt_int <= NBytes) && (state_q == IDLE);
    valid_o   = (cnt_int >= NBytes) || ((state_q == FLUSH) && (cnt_int != 0));

    for (int k = 0; k < NBytes; k++) begin
      data_o[8*k +: 8] = buf_q[k];
      // Covers both cases: all-ones when cnt >= NBytes, (1<<cnt)-1 otherwise.
      mask_o[k]        = valid_o && (k < cnt_int);
    end

    popped = 0;
    if (valid_o && ready_i) popped = (cnt_int >= NBytes) ? NBytes : cnt_int;

    // Lowest set strobe and number of strobes.
    low_idx = 0;
    found   = 1'b0;
    for (int k = 0; k < NBytes; k++) begin
      if (mask_i[k] && !found) begin
        low_idx = k;
        found   = 1'b1;
      end
    end
    n_set   = $countones(mask_i);

    // Once aligned to bit 0 a contiguous run has the form 0..01..1, so adding
    // one clears every set bit (an all-ones value wraps to zero).
    shifted   = mask_i >> low_idx;
    contig    = ((shifted & (shifted + 1'b1)) == '0);

    accept    = valid_i && ready_o;
    good_beat = accept && contig && (mask_i != '0);
    bad_beat  = accept && !contig;

    // Shift out popped bytes; zeros fill from the top so bytes beyond cnt
    // always read as zero.
    for (int i = 0; i < BufB; i++) begin
      buf_d[i] = (i + popped < BufB) ? buf_q[i + popped] : 8'h00;
    end

    // Append the new bytes after the shift.
    base = cnt_int - popped;
    if (good_beat) begin
      for (int j = 0; j < NBytes; j++) begin
        if ((j < n_set) && (base + j < BufB) && (low_idx + j < NBytes)) begin
          buf_d[base + j] = data_i[8*(low_idx + j) +: 8];
        end
      end
    end

    cnt_d = CntW'(cnt_int - popped + (good_beat ? n_set : 0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      err_q <= bad_beat;
      case (state_q)
        IDLE:    if (flush_i) state_q <= FLUSH;
        // Leaves as soon as the buffer is empty, including right after the
        // final pop, so an empty flush takes exactly one cycle in FLUSH.
        FLUSH:   if (cnt_d == '0) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign flush_done_o = (state_q == DONE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_hmac_msg_packer.sv
module tb_hmac_msg_packer;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  mask_in;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  mask_out;
  logic        ready_in;
  logic        flush;
  logic        flush_done;
  logic        err;

  int checks;
  int failures;

  hmac_msg_packer #(.Width(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (clr),
    .valid_i      (valid_in),
    .data_i       (data_in),
    .mask_i       (mask_in),
    .ready_o      (ready_out),
    .valid_o      (valid_out),
    .data_o       (data_out),
    .mask_o       (mask_out),
    .ready_i      (ready_in),
    .flush_i      (flush),
    .flush_done_o (flush_done),
    .err_o        (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] m);
    valid_in = 1'b1;
    data_in  = d;
    mask_in  = m;
  endtask

  task automatic drive_idle();
    valid_in = 1'b0;
    data_in  = '0;
    mask_in  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; flush = 1'b0; ready_in = 1'b1;
    drive_idle();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++;
    if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
    checks++;
    if (mask_out !== 4'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0", mask_out); end
    checks++;
    if (flush_done !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL reset_pulses got done=%b err=%b exp=0,0", flush_done, err);
    end
  endtask

  task automatic test_full_words();
    ready_in = 1'b1;
    drive_beat(32'h03020100, 4'hF);
    tick();
    drive_beat(32'h07060504, 4'hF);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h03020100 || mask_out !== 4'hF) begin
      failures++; $display("FAIL full_word0 got v=%b d=%h m=%h exp 1/03020100/f", valid_out, data_out, mask_out);
    end
    tick();
    drive_idle();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h07060504 || mask_out !== 4'hF) begin
      failures++; $display("FAIL full_word1 got v=%b d=%h m=%h exp 1/07060504/f", valid_out, data_out, mask_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || flush_done !== 1'b0) begin
      failures++; $display("FAIL full_after got v=%b done=%b exp 0/0", valid_out, flush_done);
    end
  endtask

  task automatic test_compact();
    ready_in = 1'b1;
    drive_beat(32'h0000BBAA, 4'h3);
    tick();
    drive_beat(32'hDDCC0000, 4'hC);
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL compact_partial got v=%b exp 0", valid_out); end
    tick();
    drive_idle();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'hDDCCBBAA || mask_out !== 4'hF) begin
      failures++; $display("FAIL compact_word got v=%b d=%h m=%h exp 1/ddccbbaa/f", valid_out, data_out, mask_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL compact_after got v=%b exp 0", valid_out); end
  endtask

  task automatic test_flush();
    ready_in = 1'b1;
    drive_beat(32'h00221100, 4'h6);
    tick();
    drive_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (ready_out !== 1'b0) begin failures++; $display("FAIL flush_ready_low got=%b exp 0", ready_out); end
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h00002211 || mask_out !== 4'h3) begin
      failures++; $display("FAIL flush_word got v=%b d=%h m=%h exp 1/00002211/3", valid_out, data_out, mask_out);
    end
    tick();
    checks++;
    if (flush_done !== 1'b1 || valid_out !== 1'b0) begin
      failures++; $display("FAIL flush_done_pulse got done=%b v=%b exp 1/0", flush_done, valid_out);
    end
    tick();
    checks++;
    if (flush_done !== 1'b0 || ready_out !== 1'b1) begin
      failures++; $display("FAIL flush_after got done=%b rdy=%b exp 0/1", flush_done, ready_out);
    end
  endtask

  task automatic test_flush_empty();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (flush_done !== 1'b0 || valid_out !== 1'b0) begin
      failures++; $display("FAIL empty_flush_early got done=%b v=%b exp 0/0", flush_done, valid_out);
    end
    tick();
    checks++;
    if (flush_done !== 1'b1) begin failures++; $display("FAIL empty_flush_done got=%b exp 1", flush_done); end
    tick();
    checks++;
    if (flush_done !== 1'b0) begin failures++; $display("FAIL empty_flush_after got=%b exp 0", flush_done); end
  endtask

  task automatic test_back_to_back();
    ready_in = 1'b0;
    drive_beat(32'h44332211, 4'hF);
    tick();
    drive_beat(32'h88776655, 4'hF);
    tick();
    drive_idle();
    checks++;
    if (ready_out !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp 0", ready_out); end
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h44332211) begin
      failures++; $display("FAIL bp_hold0 got v=%b d=%h exp 1/44332211", valid_out, data_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h44332211 || mask_out !== 4'hF) begin
      failures++; $display("FAIL bp_stable got v=%b d=%h m=%h exp 1/44332211/f", valid_out, data_out, mask_out);
    end
    ready_in = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h88776655 || ready_out !== 1'b1) begin
      failures++; $display("FAIL bp_word1 got v=%b d=%h rdy=%b exp 1/88776655/1", valid_out, data_out, ready_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL bp_after got v=%b exp 0", valid_out); end
  endtask

  task automatic test_err();
    ready_in = 1'b1;
    drive_beat(32'hAABBCCDD, 4'h5);
    tick();
    drive_idle();
    checks++;
    if (err !== 1'b1 || valid_out !== 1'b0) begin
      failures++; $display("FAIL err_pulse got err=%b v=%b exp 1/0", err, valid_out);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp 0", err); end
    drive_beat(32'h12345678, 4'hF);
    tick();
    drive_idle();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'h12345678 || mask_out !== 4'hF || err !== 1'b0) begin
      failures++; $display("FAIL err_next_beat got v=%b d=%h m=%h e=%b exp 1/12345678/f/0",
                           valid_out, data_out, mask_out, err);
    end
    tick();
  endtask

  task automatic test_clr_mid_flush();
    ready_in = 1'b0;
    drive_beat(32'h00CCBBAA, 4'h7);
    tick();
    drive_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || mask_out !== 4'h7 || data_out !== 32'h00CCBBAA) begin
      failures++; $display("FAIL clr_residual got v=%b d=%h m=%h exp 1/00ccbbaa/7", valid_out, data_out, mask_out);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ready_in = 1'b1;
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1 || flush_done !== 1'b0) begin
      failures++; $display("FAIL clr_state got v=%b rdy=%b done=%b exp 0/1/0", valid_out, ready_out, flush_done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (flush_done !== 1'b0 || valid_out !== 1'b0) begin
        failures++; $display("FAIL clr_no_done cycle=%0d got done=%b v=%b exp 0/0", i, flush_done, valid_out);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_words();
    test_compact();
    test_flush();
    test_flush_empty();
    test_back_to_back();
    test_err();
    test_clr_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
